// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 width codes, LSU FSM states
// and the request legality check used at accept time and in the align stage.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Unsigned widths exist only for loads; halves need even, words need 00 lane.
  function automatic logic lsu_fault(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] lane);
    logic f;
    case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = lane[0];
      F3_W:    f = (lane != 2'b00);
      F3_BU:   f = is_store;
      F3_HU:   f = is_store | lane[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the pipeline (master) and the data memory LSU (slave).
interface data_mem_lsu_if;
  import rv32_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] mem_data;
  logic            resp_valid;
  logic            fault;

  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, wdata,
    input  req_ready, mem_data, resp_valid, fault
  );

  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, wdata,
    output req_ready, mem_data, resp_valid, fault
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load lane extraction with sign or zero extension.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic            is_store,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] ldata,
  output logic            fault
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store path: low byte/half replicated so every candidate lane carries it.
  always_comb begin
    fault    = lsu_fault(is_store, funct3, lane);
    be       = 4'b0000;
    wdata_sh = wdata;
    if (is_store && !fault) begin
      case (funct3)
        F3_B: begin
          be       = 4'b0001 << lane;
          wdata_sh = {4{wdata[7:0]}};
        end
        F3_H: begin
          be       = lane[1] ? 4'b1100 : 4'b0011;
          wdata_sh = {2{wdata[15:0]}};
        end
        F3_W: begin
          be       = 4'b1111;
          wdata_sh = wdata;
        end
        default: begin
          be       = 4'b0000;
          wdata_sh = wdata;
        end
      endcase
    end else begin
      be       = 4'b0000;
      wdata_sh = wdata;
    end
  end

  // Load path: pick the addressed lane, then extend.
  always_comb begin
    byte_s = rword[{lane, 3'b000} +: 8];
    half_s = lane[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      F3_B:    ldata = {{24{byte_s[7]}}, byte_s};
      F3_H:    ldata = {{16{half_s[15]}}, half_s};
      F3_W:    ldata = rword;
      F3_BU:   ldata = {24'h00_0000, byte_s};
      F3_HU:   ldata = {16'h0000, half_s};
      default: ldata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with load/store alignment: IDLE->ACCESS->RESP for legal requests,
// IDLE->RESP for faulting ones. Feeds the write-back mux through mem_data.
module data_mem_lsu
  import rv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_lsu_if.slave  bus
);

  logic [XLEN-1:0] mem [0:DEPTH_WORDS-1];

  lsu_state_t      state_r;
  logic            req_ready_r;
  logic            resp_valid_r;
  logic            fault_r;
  logic [XLEN-1:0] mem_data_r;
  logic            is_store_r;
  logic [2:0]      funct3_r;
  logic [IDX_W-1:0] idx_r;
  logic [1:0]      lane_r;
  logic [XLEN-1:0] wdata_r;

  logic            accept_s;
  logic            req_fault_s;
  logic [XLEN-1:0] rword_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_sh_s;
  logic [XLEN-1:0] ldata_s;
  logic            align_fault_s;

  assign accept_s    = bus.req_valid & req_ready_r & (bus.mem_read | bus.mem_write);
  assign req_fault_s = lsu_fault(bus.mem_write, bus.funct3, bus.addr[1:0]);
  assign rword_s     = mem[idx_r];

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.fault      = fault_r;
  assign bus.mem_data   = mem_data_r;

  lsu_align u_align (
    .funct3   (funct3_r),
    .lane     (lane_r),
    .is_store (is_store_r),
    .wdata    (wdata_r),
    .rword    (rword_s),
    .be       (be_s),
    .wdata_sh (wdata_sh_s),
    .ldata    (ldata_s),
    .fault    (align_fault_s)
  );

  // Control FSM, request capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      fault_r      <= 1'b0;
      mem_data_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            is_store_r  <= bus.mem_write;
            funct3_r    <= bus.funct3;
            idx_r       <= bus.addr[IDX_W+1:2];
            lane_r      <= bus.addr[1:0];
            wdata_r     <= bus.wdata;
            req_ready_r <= 1'b0;
            if (req_fault_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              fault_r      <= 1'b1;
              mem_data_r   <= 32'h0000_0000;
            end else begin
              state_r <= ACCESS;
            end
          end
        end
        ACCESS: begin
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          fault_r      <= align_fault_s;
          mem_data_r   <= (is_store_r | align_fault_s) ? 32'h0000_0000 : ldata_s;
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Array write: byte-enabled, only in ACCESS, suppressed by reset at the same edge.
  always_ff @(posedge clk) begin
    if (!rst && state_r == ACCESS && is_store_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_r][8*i +: 8] <= wdata_sh_s[8*i +: 8];
        end
      end
    end
  end

endmodule
